// File: rtl/vdp_cpu_port_if.sv
// vdp_cpu_port_if
// Purpose: request/acknowledge bus between the VDP CPU port and the VRAM
//          arbiter. The CPU port is the master and the arbiter is the slave.
// Signals:
//   vram_req   - request, held until acknowledged (master -> slave)
//   vram_we    - 1 = write, 0 = read, valid while vram_req is high
//   vram_addr  - VRAM address, stable while vram_req is high
//   vram_wdata - write data
//   vram_ack   - one-cycle completion pulse (slave -> master)
//   vram_rdata - read data, valid in the vram_ack cycle
interface vdp_cpu_port_if #(
  parameter int ADDR_W = 14
) ();
  logic              vram_req;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              vram_ack;
  logic [7:0]        vram_rdata;

  modport master (
    output vram_req, vram_we, vram_addr, vram_wdata,
    input  vram_ack, vram_rdata
  );

  modport slave (
    input  vram_req, vram_we, vram_addr, vram_wdata,
    output vram_ack, vram_rdata
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// vdp_cpu_port
// Purpose: CPU-facing port of a TMS9918-style VDP. Decodes CPU strobes into
//          two-byte control sequences (register writes / address setup),
//          status reads, and data-port VRAM accesses with read-ahead buffer.
// Ports:
//   pxclk, reset_n        - clock (rising edge), async active-low reset
//   cpu_wr, cpu_rd        - one-cycle CPU strobes (write wins if both)
//   cpu_mode              - 0 = data port, 1 = control port
//   cpu_din / cpu_dout    - CPU write data / registered read data
//   cpu_busy              - a VRAM transaction is outstanding
//   status_in / status_rd - VDP status byte / one-cycle read pulse
//   reg_wr, reg_num, reg_data - register write pulse and its payload
//   vram                  - master side of the VRAM request/ack bus
module vdp_cpu_port #(
  parameter int ADDR_W = 14
) (
  input  logic                  pxclk,
  input  logic                  reset_n,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  input  logic                  cpu_mode,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  cpu_busy,
  input  logic [7:0]            status_in,
  output logic                  status_rd,
  output logic                  reg_wr,
  output logic [2:0]            reg_num,
  output logic [7:0]            reg_data,
  vdp_cpu_port_if.master        vram
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } vramState_t;

  vramState_t        r_state;
  logic              r_ff;
  logic [7:0]        r_lat;
  logic [ADDR_W-1:0] r_ptr;
  logic [7:0]        r_rab;
  logic [7:0]        r_dout;
  logic              r_busy;
  logic              r_statusRd;
  logic              r_regWr;
  logic [2:0]        r_regNum;
  logic [7:0]        r_regData;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;

  // A simultaneous read and write is treated as a write only.
  logic              w_ctrlWr;
  logic              w_ctrlRd;
  logic              w_dataWr;
  logic              w_dataRd;
  logic [ADDR_W-1:0] w_newPtr;

  assign w_ctrlWr = cpu_wr & cpu_mode;
  assign w_dataWr = cpu_wr & ~cpu_mode;
  assign w_ctrlRd = cpu_rd & ~cpu_wr & cpu_mode;
  assign w_dataRd = cpu_rd & ~cpu_wr & ~cpu_mode;
  assign w_newPtr = {cpu_din[ADDR_W-9:0], r_lat};

  // Single sequential block: CPU strobe decode plus the IDLE/REQ handshake.
  // r_busy stays high for one extra IDLE cycle after the ack so the CPU
  // sees the transaction as outstanding until the cycle after vram_ack.
  always_ff @(posedge pxclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_ff       <= 1'b0;
      r_lat      <= '0;
      r_ptr      <= '0;
      r_rab      <= '0;
      r_dout     <= '0;
      r_busy     <= 1'b0;
      r_statusRd <= 1'b0;
      r_regWr    <= 1'b0;
      r_regNum   <= '0;
      r_regData  <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_statusRd <= 1'b0;
      r_regWr    <= 1'b0;

      if (w_ctrlRd) begin
        r_ff       <= 1'b0;
        r_dout     <= status_in;
        r_statusRd <= 1'b1;
      end else if (w_ctrlWr) begin
        if (!r_ff) begin
          r_lat <= cpu_din;
          r_ff  <= 1'b1;
        end else if (cpu_din[7]) begin
          r_regWr   <= 1'b1;
          r_regNum  <= cpu_din[2:0];
          r_regData <= r_lat;
          r_ff      <= 1'b0;
        end else if (cpu_din[6]) begin
          r_ptr <= w_newPtr;
          r_ff  <= 1'b0;
        end else if (!r_busy) begin
          // Address setup with read-ahead: fetch at the new pointer.
          r_addr  <= w_newPtr;
          r_ptr   <= w_newPtr + ADDR_W'(1);
          r_we    <= 1'b0;
          r_req   <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= REQ;
          r_ff    <= 1'b0;
        end
      end else if (w_dataWr && !r_busy) begin
        r_addr  <= r_ptr;
        r_wdata <= cpu_din;
        r_rab   <= cpu_din;
        r_ptr   <= r_ptr + ADDR_W'(1);
        r_we    <= 1'b1;
        r_req   <= 1'b1;
        r_busy  <= 1'b1;
        r_state <= REQ;
        r_ff    <= 1'b0;
      end else if (w_dataRd && !r_busy) begin
        r_dout  <= r_rab;
        r_addr  <= r_ptr;
        r_ptr   <= r_ptr + ADDR_W'(1);
        r_we    <= 1'b0;
        r_req   <= 1'b1;
        r_busy  <= 1'b1;
        r_state <= REQ;
        r_ff    <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_busy) begin
            r_busy <= 1'b0;
          end
        end
        REQ: begin
          if (vram.vram_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
            if (!r_we) begin
              r_rab <= vram.vram_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cpu_dout        = r_dout;
  assign cpu_busy        = r_busy;
  assign status_rd       = r_statusRd;
  assign reg_wr          = r_regWr;
  assign reg_num         = r_regNum;
  assign reg_data        = r_regData;
  assign vram.vram_req   = r_req;
  assign vram.vram_we    = r_we;
  assign vram.vram_addr  = r_addr;
  assign vram.vram_wdata = r_wdata;

endmodule
